// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: flags register, direction/target decision, redirect pulse and squash window.
// Optional return-address stack enabled by defining BRANCH_RAS_EN.
module branch_resolve_unit #(
  parameter int FLUSH_CYCLES = 3,
  parameter int RAS_DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic        EX_Valid,
  input  logic        EX_isCmp,
  input  logic [1:0]  ALU_Flags,
  input  logic [4:0]  EX_Branch_Signals,
  input  logic [31:0] EX_PC,
  input  logic [31:0] EX_BranchTarget,
  input  logic [31:0] EX_RA_Value,
  output logic [1:0]  Flags_Out,
  output logic        Branch_Taken,
  output logic [31:0] Branch_PC,
  output logic        Flush,
  output logic        Link_We,
  output logic [31:0] Link_Addr
);

  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7 || RAS_DEPTH < 1) begin : g_bad_param
    $error("branch_resolve_unit: FLUSH_CYCLES must be 1..7 and RAS_DEPTH >= 1");
  end

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_FLUSH = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [1:0]  flags_q, flags_d;
  logic        taken_q, taken_d;
  logic [31:0] bpc_q, bpc_d;
  logic        lwe_q, lwe_d;
  logic [31:0] laddr_q, laddr_d;

  logic        accept;
  logic        is_ret, is_call, is_ubr, is_bgt, is_beq;
  logic        br_taken;
  logic [31:0] link_addr;
  logic [31:0] ret_target;

  // Priority decode: Ret > Call > UBranch > Bgt > Beq
  assign is_ret  = EX_Branch_Signals[4];
  assign is_call = EX_Branch_Signals[3] & ~EX_Branch_Signals[4];
  assign is_ubr  = EX_Branch_Signals[2] & ~(|EX_Branch_Signals[4:3]);
  assign is_bgt  = EX_Branch_Signals[1] & ~(|EX_Branch_Signals[4:2]);
  assign is_beq  = EX_Branch_Signals[0] & ~(|EX_Branch_Signals[4:1]);

  assign accept    = EX_Valid & ~Stall & (state_q == S_IDLE);
  assign br_taken  = accept & (is_ret | is_call | is_ubr |
                               (is_bgt & flags_q[1]) | (is_beq & flags_q[0]));
  assign link_addr = EX_PC + 32'd4;

`ifdef BRANCH_RAS_EN
  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic [31:0]   ras_q [RAS_DEPTH];
  logic [PW-1:0] ras_ptr_q;
  logic [CW-1:0] ras_cnt_q;
  logic [PW-1:0] ptr_inc, ptr_dec;

  // Circular buffer: a push onto a full stack overwrites the oldest slot.
  assign ptr_inc    = (ras_ptr_q == PW'(RAS_DEPTH - 1)) ? '0 : ras_ptr_q + 1'b1;
  assign ptr_dec    = (ras_ptr_q == '0) ? PW'(RAS_DEPTH - 1) : ras_ptr_q - 1'b1;
  assign ret_target = (ras_cnt_q != '0) ? ras_q[ptr_dec] : EX_RA_Value;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
      ras_ptr_q <= '0;
      ras_cnt_q <= '0;
    end else if (accept && is_call) begin
      ras_q[ras_ptr_q] <= link_addr;
      ras_ptr_q        <= ptr_inc;
      if (ras_cnt_q != CW'(RAS_DEPTH)) ras_cnt_q <= ras_cnt_q + 1'b1;
    end else if (accept && is_ret && (ras_cnt_q != '0)) begin
      ras_ptr_q <= ptr_dec;
      ras_cnt_q <= ras_cnt_q - 1'b1;
    end
  end
`else
  assign ret_target = EX_RA_Value;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flags_d = flags_q;
    taken_d = 1'b0;
    bpc_d   = bpc_q;
    lwe_d   = 1'b0;
    laddr_d = laddr_q;

    if (accept && EX_isCmp) flags_d = ALU_Flags;

    unique case (state_q)
      S_IDLE: begin
        if (br_taken) begin
          taken_d = 1'b1;
          bpc_d   = is_ret ? ret_target : EX_BranchTarget;
          state_d = S_FLUSH;
          cnt_d   = 3'(FLUSH_CYCLES - 1);
        end
        if (accept && is_call) begin
          lwe_d   = 1'b1;
          laddr_d = link_addr;
        end
      end
      S_FLUSH: begin
        if (!Stall) begin
          if (cnt_q == 3'd0) state_d = S_IDLE;
          else               cnt_d   = cnt_q - 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      flags_q <= '0;
      taken_q <= 1'b0;
      bpc_q   <= '0;
      lwe_q   <= 1'b0;
      laddr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flags_q <= flags_d;
      taken_q <= taken_d;
      bpc_q   <= bpc_d;
      lwe_q   <= lwe_d;
      laddr_q <= laddr_d;
    end
  end

  assign Flags_Out    = flags_q;
  assign Branch_Taken = taken_q;
  assign Branch_PC    = bpc_q;
  assign Flush        = (state_q == S_FLUSH);
  assign Link_We      = lwe_q;
  assign Link_Addr    = laddr_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit; expected outputs queued per driven cycle, checked after the edge.
module tb_branch_resolve_unit;

  localparam logic [4:0] NONE = 5'b00000;
  localparam logic [4:0] BEQ  = 5'b00001;
  localparam logic [4:0] BGT  = 5'b00010;
  localparam logic [4:0] UBR  = 5'b00100;
  localparam logic [4:0] CALL = 5'b01000;
  localparam logic [4:0] RET  = 5'b10000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Stall = 1'b0;
  logic        EX_Valid = 1'b0;
  logic        EX_isCmp = 1'b0;
  logic [1:0]  ALU_Flags = '0;
  logic [4:0]  EX_Branch_Signals = '0;
  logic [31:0] EX_PC = '0;
  logic [31:0] EX_BranchTarget = '0;
  logic [31:0] EX_RA_Value = '0;
  logic [1:0]  Flags_Out;
  logic        Branch_Taken;
  logic [31:0] Branch_PC;
  logic        Flush;
  logic        Link_We;
  logic [31:0] Link_Addr;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        tk;
    logic [31:0] pc;
    logic        fl;
    logic        lwe;
    logic [31:0] la;
    logic [1:0]  flags;
  } exp_t;

  exp_t sb[$];

  branch_resolve_unit dut (
    .clk(clk), .reset(reset), .Stall(Stall), .EX_Valid(EX_Valid), .EX_isCmp(EX_isCmp),
    .ALU_Flags(ALU_Flags), .EX_Branch_Signals(EX_Branch_Signals), .EX_PC(EX_PC),
    .EX_BranchTarget(EX_BranchTarget), .EX_RA_Value(EX_RA_Value), .Flags_Out(Flags_Out),
    .Branch_Taken(Branch_Taken), .Branch_PC(Branch_PC), .Flush(Flush), .Link_We(Link_We),
    .Link_Addr(Link_Addr)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int step, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s step=%0d observed=%h expected=%h", tag, step, obs, exp);
    end
  endtask

  int step = 0;

  // Drive one cycle, queue the expected post-edge outputs, then compare after the edge.
  task automatic cyc(input logic v, input logic st, input logic cmp, input logic [1:0] af,
                     input logic [4:0] br, input logic [31:0] pc, input logic [31:0] tgt,
                     input logic [31:0] ra, input logic e_tk, input logic [31:0] e_pc,
                     input logic e_fl, input logic e_lwe, input logic [31:0] e_la,
                     input logic [1:0] e_flags);
    exp_t e;
    EX_Valid = v; Stall = st; EX_isCmp = cmp; ALU_Flags = af; EX_Branch_Signals = br;
    EX_PC = pc; EX_BranchTarget = tgt; EX_RA_Value = ra;
    e.tk = e_tk; e.pc = e_pc; e.fl = e_fl; e.lwe = e_lwe; e.la = e_la; e.flags = e_flags;
    sb.push_back(e);
    @(posedge clk);
    #1;
    step++;
    e = sb.pop_front();
    chk("Branch_Taken", step, {31'd0, Branch_Taken}, {31'd0, e.tk});
    chk("Branch_PC",    step, Branch_PC, e.pc);
    chk("Flush",        step, {31'd0, Flush}, {31'd0, e.fl});
    chk("Link_We",      step, {31'd0, Link_We}, {31'd0, e.lwe});
    chk("Link_Addr",    step, Link_Addr, e.la);
    chk("Flags_Out",    step, {30'd0, Flags_Out}, {30'd0, e.flags});
  endtask

  task automatic idle(input logic e_fl, input logic [31:0] pc, input logic [31:0] la, input logic [1:0] fl);
    cyc(0, 0, 0, 2'b00, NONE, 32'h0, 32'h0, 32'h0, 0, pc, e_fl, 0, la, fl);
  endtask

  // Three cycles following a taken branch: Flush 1, 1, then back to 0.
  task automatic drain(input logic [31:0] pc, input logic [31:0] la, input logic [1:0] fl);
    idle(1, pc, la, fl);
    idle(1, pc, la, fl);
    idle(0, pc, la, fl);
  endtask

  logic [31:0] ret_exp;
  logic [31:0] wrap_ret_exp;
  logic [31:0] ras_exp [5];

  initial begin
`ifdef BRANCH_RAS_EN
    ret_exp      = 32'h44;
    wrap_ret_exp = 32'h0;
    ras_exp[0] = 32'h44; ras_exp[1] = 32'h34; ras_exp[2] = 32'h24;
    ras_exp[3] = 32'h14; ras_exp[4] = 32'hBAD;
`else
    ret_exp      = 32'h999;
    wrap_ret_exp = 32'h123;
    for (int i = 0; i < 5; i++) ras_exp[i] = 32'hBAD;
`endif

    // Reset values
    reset = 1'b1;
    idle(0, 32'h0, 32'h0, 2'b00);
    reset = 1'b0;

    // cmp 01 then beq taken, Flush exactly 3 cycles
    cyc(1, 0, 1, 2'b01, NONE, 32'h0FC, 32'h0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 2'b01);
    cyc(1, 0, 0, 2'b00, BEQ, 32'h100, 32'h200, 32'h0, 1, 32'h200, 1, 0, 32'h0, 2'b01);
    drain(32'h200, 32'h0, 2'b01);

    // bgt with positive flag clear: not taken
    cyc(1, 0, 0, 2'b00, BGT, 32'h104, 32'h300, 32'h0, 0, 32'h200, 0, 0, 32'h0, 2'b01);

    // call then ret
    cyc(1, 0, 0, 2'b00, CALL, 32'h40, 32'h80, 32'h999, 1, 32'h80, 1, 1, 32'h44, 2'b01);
    drain(32'h80, 32'h44, 2'b01);
    cyc(1, 0, 0, 2'b00, RET, 32'h80, 32'h0, 32'h999, 1, ret_exp, 1, 0, 32'h44, 2'b01);
    // squashed cmp and beq during flush
    cyc(1, 0, 1, 2'b10, NONE, 32'h84, 32'h0, 32'h0, 0, ret_exp, 1, 0, 32'h44, 2'b01);
    cyc(1, 0, 0, 2'b00, BEQ, 32'h88, 32'h250, 32'h0, 0, ret_exp, 1, 0, 32'h44, 2'b01);
    idle(0, ret_exp, 32'h44, 2'b01);

    // Stall 2 cycles mid-flush stretches Flush to 5 cycles
    cyc(1, 0, 0, 2'b00, UBR, 32'h90, 32'h500, 32'h0, 1, 32'h500, 1, 0, 32'h44, 2'b01);
    cyc(0, 1, 0, 2'b00, NONE, 32'h0, 32'h0, 32'h0, 0, 32'h500, 1, 0, 32'h44, 2'b01);
    cyc(0, 1, 0, 2'b00, NONE, 32'h0, 32'h0, 32'h0, 0, 32'h500, 1, 0, 32'h44, 2'b01);
    idle(1, 32'h500, 32'h44, 2'b01);
    idle(1, 32'h500, 32'h44, 2'b01);
    idle(0, 32'h500, 32'h44, 2'b01);

    // Stall in IDLE blocks acceptance of branch and cmp
    cyc(1, 1, 0, 2'b00, BEQ, 32'hA0, 32'h5A0, 32'h0, 0, 32'h500, 0, 0, 32'h44, 2'b01);
    cyc(1, 1, 1, 2'b10, NONE, 32'hA0, 32'h0, 32'h0, 0, 32'h500, 0, 0, 32'h44, 2'b01);

    // Reset in second flush cycle
    cyc(1, 0, 0, 2'b00, UBR, 32'hB0, 32'h600, 32'h0, 1, 32'h600, 1, 0, 32'h44, 2'b01);
    reset = 1'b1;
    idle(0, 32'h0, 32'h0, 2'b00);
    reset = 1'b0;
    cyc(1, 0, 0, 2'b00, BEQ, 32'hC0, 32'h700, 32'h0, 0, 32'h0, 0, 0, 32'h0, 2'b00);

    // cmp 10: beq not taken, bgt taken
    cyc(1, 0, 1, 2'b10, NONE, 32'hC4, 32'h0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 2'b10);
    cyc(1, 0, 0, 2'b00, BEQ, 32'hC8, 32'h750, 32'h0, 0, 32'h0, 0, 0, 32'h0, 2'b10);
    cyc(1, 0, 0, 2'b00, BGT, 32'hCC, 32'h800, 32'h0, 1, 32'h800, 1, 0, 32'h0, 2'b10);
    drain(32'h800, 32'h0, 2'b10);

    // All branch bits set: Ret wins, no link write; stack empty after reset
    cyc(1, 0, 0, 2'b00, 5'b11111, 32'h900, 32'h880, 32'hABC, 1, 32'hABC, 1, 0, 32'h0, 2'b10);
    drain(32'hABC, 32'h0, 2'b10);

    // Invalid slot ignored
    cyc(0, 0, 0, 2'b00, UBR, 32'h904, 32'hDEAD, 32'h0, 0, 32'hABC, 0, 0, 32'h0, 2'b10);

    // Link address wraps mod 2^32
    cyc(1, 0, 0, 2'b00, CALL, 32'hFFFF_FFFC, 32'h10, 32'h0, 1, 32'h10, 1, 1, 32'h0, 2'b10);
    drain(32'h10, 32'h0, 2'b10);
    cyc(1, 0, 0, 2'b00, RET, 32'h10, 32'h0, 32'h123, 1, wrap_ret_exp, 1, 0, 32'h0, 2'b10);
    drain(wrap_ret_exp, 32'h0, 2'b10);

    // Five calls overflow a 4-deep stack, then five rets
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 0, 2'b00, CALL, 32'(i * 16), 32'h80, 32'h0, 1, 32'h80, 1, 1, 32'(i * 16 + 4), 2'b10);
      drain(32'h80, 32'(i * 16 + 4), 2'b10);
    end
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 0, 2'b00, RET, 32'h200, 32'h0, 32'hBAD, 1, ras_exp[i], 1, 0, 32'h44, 2'b10);
      drain(ras_exp[i], 32'h44, 2'b10);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Resolves control-flow instructions in the EX stage of the pipelined processor. Holds the architectural flags register written by compare results from the ALU, decides branch direction and target, and drives the fetch redirect and IF/ID/EX squash sequence. It sits beside the ALU in EX, consuming its `flags` output and feeding the PC-select mux and pipeline-register flush inputs.

## Interface

- `FLUSH_CYCLES`, 3, number of cycles `Flush` stays high after a taken branch (1..7)
- `RAS_DEPTH`, 4, return-address-stack entries; used only with `RAS_EN`
- `clk` in 1: single clock; all state updates on rising edge
- `reset` in 1: synchronous, active-high
- `Stall` in 1: pipeline stall; EX instruction not consumed this cycle
- `EX_Valid` in 1: EX slot holds a real instruction
- `EX_isCmp` in 1: EX instruction is `cmp`
- `ALU_Flags` in 2: from ALU; [0]=zero, [1]=positive
- `EX_Branch_Signals` in 5: one-hot-ish; [0]=isBeq, [1]=isBgt, [2]=isUBranch, [3]=isCall, [4]=isRet
- `EX_PC` in 32: PC of EX instruction
- `EX_BranchTarget` in 32: precomputed immediate target
- `EX_RA_Value` in 32: return-address register value read in ID
- `Flags_Out` out 2: flags register
- `Branch_Taken` out 1: one-cycle redirect pulse
- `Branch_PC` out 32: redirect target, valid with `Branch_Taken`
- `Flush` out 1: squash younger instructions
- `Link_We` out 1: one-cycle pulse, write `Link_Addr` to return-address register
- `Link_Addr` out 32: `EX_PC + 4`

## Operation

- States: IDLE, FLUSH (with 3-bit down-counter).
- Accept condition: `EX_Valid & !Stall & state==IDLE`. Instructions arriving in FLUSH are squashed: no flag update, no branch, no link.
- Flag capture: accepted `EX_isCmp` → `Flags_Out <= ALU_Flags` next edge. Otherwise flags hold.
- Branch priority when several bits set: Ret > Call > UBranch > Bgt > Beq.
- Taken: Beq if `Flags_Out[0]`; Bgt if `Flags_Out[1]`; UBranch, Call, Ret always. Conditions use registered flags, so cmp followed immediately by a branch sees the new flags.
- Target: Ret → return address (see Configuration); others → `EX_BranchTarget`.
- Call: `Link_We=1`, `Link_Addr=EX_PC+4` (mod 2^32 wrap).
- Taken branch → state FLUSH, counter=FLUSH_CYCLES-1; FLUSH decrements each non-stalled cycle, returns to IDLE when counter is 0.
- Not-taken conditional branch: no outputs, stays IDLE.
- `Stall=1`: no acceptance, state/counter/flags frozen; pulses (`Branch_Taken`, `Link_We`) drop to 0; `Flush` holds its value.

## Timing

- Reset values: `Flags_Out=0`, `Branch_Taken=0`, `Branch_PC=0`, `Flush=0`, `Link_We=0`, `Link_Addr=0`, state IDLE, RAS empty.
- Latency 1: branch accepted at edge-cycle n → `Branch_Taken`, `Branch_PC`, `Flush`, `Link_*` valid in cycle n+1.
- `Flush` high cycles n+1 .. n+FLUSH_CYCLES (excluding stalled cycles); `Branch_PC` holds until next taken branch.
- Back-to-back taken branches are impossible; second is squashed.
- Reset mid-FLUSH: all outputs at reset values the cycle after reset; squash abandoned.

## Configuration

- `BRANCH_RAS_EN` defined: internal stack of `RAS_DEPTH` 32-bit entries. Accepted Call pushes `EX_PC+4`; full stack overwrites oldest entry, count saturates. Accepted Ret pops top and uses it as target; empty stack falls back to `EX_RA_Value`. Stack cleared on reset.
- Not defined: no stack; Ret target is always `EX_RA_Value`; `RAS_DEPTH` ignored.

## Test plan

- cmp with `ALU_Flags=01`, then beq `EX_PC=0x100`, target `0x200` → `Flags_Out=01`; next cycle `Branch_Taken=1`, `Branch_PC=0x200`, `Flush` high exactly 3 cycles.
- `Flags_Out=01`, bgt target `0x300` → `Branch_Taken=0`, `Flush=0`, state IDLE.
- call `EX_PC=0x40`, target `0x80`; later ret with `EX_RA_Value=0x999` → `Link_We=1`, `Link_Addr=0x44`, `Branch_PC=0x80`; ret `Branch_PC=0x44` with `BRANCH_RAS_EN`, `0x999` without.
- During FLUSH present cmp `ALU_Flags=10` and beq → `Flags_Out` unchanged, no second `Branch_Taken`; `Stall=1` for 2 cycles mid-flush extends `Flush` to 5 cycles.
- Assert `reset` in second flush cycle → next cycle all outputs 0, state IDLE, following beq with zero flags clear not taken.
- `BRANCH_RAS_EN`: calls at `0x0,0x10,0x20,0x30,0x40`, five rets with `EX_RA_Value=0xBAD` → targets `0x44,0x34,0x24,0x14,0xBAD`.
